decoder_stream: RTL and testbench



---
 rtl/decoder_pkg.sv | 27 ++
 rtl/decoder_stream_if.sv | 28 ++
 rtl/decoder_core.sv | 22 ++
 rtl/decoder_stream.sv | 151 +++++++++++++++
 tb/tb_decoder_stream.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the streaming select-line decoder: request modes, FSM states
// and the sweep end-of-range test.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'd0,
    MODE_THERMO = 2'd1,
    MODE_SWEEP  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_SWEEP = 2'd2
  } state_e;

  // True when the beat carrying `code` is the final one of a sweep ending at `end_code`.
  function automatic logic sweep_is_last(input logic [31:0] code,
                                         input logic [31:0] stride,
                                         input logic [31:0] end_code);
    logic [32:0] nxt;
    nxt = {1'b0, code} + {1'b0, stride};
    return nxt > {1'b0, end_code};
  endfunction

endpackage

// File: rtl/decoder_stream_if.sv
// Request and select-vector streams of the decoder, plus its status pulses.
interface decoder_stream_if #(
  parameter int IN_W = 5
) ();
  localparam int OUT_W = 2 ** IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic [IN_W-1:0]  out_code;
  logic             busy;
  logic             sweep_done;
  logic             err;

  modport slave (
    input  in_valid, in_code, in_mode, out_ready,
    output in_ready, out_valid, out, out_code, busy, sweep_done, err
  );

  modport master (
    output in_valid, in_code, in_mode, out_ready,
    input  in_ready, out_valid, out, out_code, busy, sweep_done, err
  );
endinterface

// File: rtl/decoder_core.sv
// Combinational N-to-2^N decoder: one-hot (bit c only) or thermometer (bits c..0).
module decoder_core #(
  parameter int IN_W = 5
) (
  input  logic [IN_W-1:0]      code,
  input  logic                 thermo,
  output logic [2**IN_W-1:0]   dec
);

  // Per-bit select: equality for one-hot, less-or-equal for thermometer.
  always_comb begin
    dec = '0;
    for (int i = 0; i < 2 ** IN_W; i++) begin
      if (thermo) begin
        dec[i] = (IN_W'(i) <= code);
      end else begin
        dec[i] = (IN_W'(i) == code);
      end
    end
  end

endmodule

// File: rtl/decoder_stream.sv
// Registered stream decoder: one-hot / thermometer beats on request, or an
// autonomous walking-one sweep from code 0 up to a latched end code.
module decoder_stream
  import decoder_pkg::*;
#(
  parameter int IN_W         = 5,
  parameter int SWEEP_STRIDE = 1
) (
  input  logic            clk,
  input  logic            rst,
  decoder_stream_if.slave bus
);

  localparam int OUT_W = 2 ** IN_W;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  code_q, code_d;
  logic [IN_W-1:0]  end_q, end_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             in_ready_s;
  logic             accept_s;
  logic             drain_s;
  logic [IN_W-1:0]  load_code_s;
  logic             load_thermo_s;
  logic [OUT_W-1:0] dec_s;
  mode_e            mode_s;

  assign mode_s   = mode_e'(bus.in_mode);
  assign accept_s = bus.in_valid & in_ready_s;
  assign drain_s  = valid_q & bus.out_ready;

  // Ready is low throughout reset and in SWEEP; in HOLD it follows the consumer.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_s = ~rst;
      S_HOLD:  in_ready_s = bus.out_ready;
      S_SWEEP: in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Code fed to the decoder for whichever beat may be loaded this cycle.
  always_comb begin
    if (state_q == S_SWEEP) begin
      load_code_s   = code_q + IN_W'(SWEEP_STRIDE);
      load_thermo_s = 1'b0;
    end else if (mode_s == MODE_SWEEP) begin
      load_code_s   = {IN_W{1'b0}};
      load_thermo_s = 1'b0;
    end else begin
      load_code_s   = bus.in_code;
      load_thermo_s = (mode_s == MODE_THERMO);
    end
  end

  decoder_core #(.IN_W(IN_W)) u_core (
    .code   (load_code_s),
    .thermo (load_thermo_s),
    .dec    (dec_s)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    code_d  = code_q;
    end_d   = end_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (state_q == S_SWEEP) begin
      if (drain_s) begin
        if (last_q) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          out_d  = dec_s;
          code_d = load_code_s;
          last_d = sweep_is_last(32'(load_code_s), 32'(SWEEP_STRIDE), 32'(end_q));
        end
      end else begin
        state_d = S_SWEEP;
      end
    end else if (accept_s) begin
      // An accept in HOLD implies out_ready, so the presented beat drains this cycle.
      case (mode_s)
        MODE_ONEHOT, MODE_THERMO: begin
          state_d = S_HOLD;
          out_d   = dec_s;
          code_d  = bus.in_code;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
        MODE_SWEEP: begin
          state_d = S_SWEEP;
          out_d   = dec_s;
          code_d  = {IN_W{1'b0}};
          end_d   = bus.in_code;
          valid_d = 1'b1;
          last_d  = sweep_is_last(32'd0, 32'(SWEEP_STRIDE), 32'(bus.in_code));
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          err_d   = 1'b1;
        end
      endcase
    end else if (drain_s) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers; reset clears every visible output at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      code_q  <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      code_q  <= code_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = valid_q;
  assign bus.out        = out_q;
  assign bus.out_code   = code_q;
  assign bus.busy       = (state_q == S_SWEEP);
  assign bus.sweep_done = last_q & valid_q & bus.out_ready & (state_q == S_SWEEP);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_decoder_stream.sv
// Bench for decoder_stream: directed scenarios plus random traffic checked
// against a queue-of-expected-beats model built from the decode/sweep rules.
module tb_decoder_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  decoder_stream_if #(.IN_W(5)) b  ();
  decoder_stream_if #(.IN_W(5)) b3 ();

  decoder_stream #(.IN_W(5), .SWEEP_STRIDE(1)) dut  (.clk(clk), .rst(rst), .bus(b));
  decoder_stream #(.IN_W(5), .SWEEP_STRIDE(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] o;
    logic [4:0]  c;
    bit          last;
    bit          sw;
  } beat_t;

  beat_t q[$];
  bit    err_exp = 1'b0;

  function automatic beat_t mk_beat(input int code, input bit thermo, input bit last, input bit sw);
    beat_t     bt;
    logic [32:0] t;
    t = (33'd1 << (code + 1)) - 33'd1;
    bt.o    = thermo ? t[31:0] : (32'd1 << code);
    bt.c    = 5'(code);
    bt.last = last;
    bt.sw   = sw;
    return bt;
  endfunction

  // Reference model for the stride-1 instance, evaluated between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      bit exp_busy;
      exp_busy = (q.size() > 0) && q[0].sw;
      check("valid", b.out_valid, q.size() > 0);
      check("busy", b.busy, exp_busy);
      check("err", b.err, err_exp);
      check("in_ready", b.in_ready, exp_busy ? 1'b0 : ((q.size() > 0) ? b.out_ready : 1'b1));
      if (q.size() > 0) begin
        check("out", b.out, q[0].o);
        check("out_code", b.out_code, q[0].c);
        if (b.out_ready) begin
          check("sweep_done", b.sweep_done, q[0].last);
          void'(q.pop_front());
        end else begin
          check("sweep_done_stall", b.sweep_done, 1'b0);
        end
      end else begin
        check("sweep_done_idle", b.sweep_done, 1'b0);
      end
      err_exp = 1'b0;
      if (b.in_valid && b.in_ready) begin
        case (b.in_mode)
          2'd0: q.push_back(mk_beat(int'(b.in_code), 1'b0, 1'b0, 1'b0));
          2'd1: q.push_back(mk_beat(int'(b.in_code), 1'b1, 1'b0, 1'b0));
          2'd2: begin
            for (int v = 0; v < 64; v += 1) begin
              bit lst;
              lst = (v + 1) > int'(b.in_code);
              q.push_back(mk_beat(v, 1'b0, lst, 1'b1));
              if (lst) break;
            end
          end
          default: err_exp = 1'b1;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request on the stride-1 instance and wait (bounded) for acceptance.
  task automatic send(input logic [1:0] m, input logic [4:0] c);
    int n;
    n = 0;
    b.in_valid = 1'b1;
    b.in_mode  = m;
    b.in_code  = c;
    @(negedge clk);
    while (!b.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", b.in_ready, 1'b1);
    step();
    b.in_valid = 1'b0;
  endtask

  initial begin
    int beats;
    int dn;
    int dn_at;
    int idx;
    bit found;

    b.in_valid = 1'b0;  b.in_mode = 2'd0;  b.in_code = 5'd0;  b.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_mode = 2'd0; b3.in_code = 5'd0; b3.out_ready = 1'b0;

    #3;
    check("rst_valid", b.out_valid, 1'b0);
    check("rst_ready", b.in_ready, 1'b0);
    check("rst_out", b.out, 32'd0);
    check("rst_busy", b.busy, 1'b0);
    check("rst_err", b.err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", b.in_ready, 1'b1);
    step();

    // One-hot codes 0..31 back to back.
    b.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      b.in_valid = 1'b1; b.in_mode = 2'd0; b.in_code = 5'(i);
      @(negedge clk);
      check("b2b_ready", b.in_ready, 1'b1);
      if (i > 0) check("b2b_out", b.out, 32'd1 << (i - 1));
      step();
    end
    b.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_last", b.out, 32'h8000_0000);
    step();

    // Thermometer spot values.
    send(2'd1, 5'd4);
    @(negedge clk); check("thermo4", b.out, 32'h0000_001F); step();
    send(2'd1, 5'd31);
    @(negedge clk); check("thermo31", b.out, 32'hFFFF_FFFF); step();
    send(2'd1, 5'd0);
    @(negedge clk); check("thermo0", b.out, 32'h0000_0001); step();

    // Full stride-1 sweep to 31.
    send(2'd2, 5'd31);
    beats = 0; dn = 0; dn_at = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b.out_valid && b.out_ready) beats++;
      if (b.sweep_done) begin dn++; dn_at = beats; end
    end
    check("sweep_beats", beats, 32);
    check("sweep_done_cnt", dn, 1);
    check("sweep_done_at", dn_at, 32);
    step();

    // Stride-3 sweep to 10 with a toggling consumer.
    b3.in_valid = 1'b1; b3.in_mode = 2'd2; b3.in_code = 5'd10;
    @(negedge clk);
    check("s3_accept", b3.in_ready, 1'b1);
    step();
    b3.in_valid = 1'b0;
    idx = 0;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      b3.out_ready = (k % 2) == 0;
      @(negedge clk);
      check("s3_valid", b3.out_valid, 1'b1);
      check("s3_out", b3.out, 32'd1 << (3 * idx));
      check("s3_code", b3.out_code, 3 * idx);
      check("s3_done", b3.sweep_done, b3.out_ready && idx == 3);
      check("s3_ready", b3.in_ready, 1'b0);
      if (b3.out_ready) idx++;
      step();
    end
    check("s3_count", idx, 4);
    @(negedge clk);
    check("s3_idle_valid", b3.out_valid, 1'b0);
    check("s3_idle_busy", b3.busy, 1'b0);
    step();

    // Stall with a pending request, then same-cycle accept on drain.
    b.out_ready = 1'b0;
    send(2'd0, 5'd7);
    b.in_valid = 1'b1; b.in_mode = 2'd0; b.in_code = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out", b.out, 32'h80);
      check("hold_ready", b.in_ready, 1'b0);
      step();
    end
    b.out_ready = 1'b1;
    @(negedge clk);
    check("drain_ready", b.in_ready, 1'b1);
    step();
    b.in_valid = 1'b0;
    @(negedge clk);
    check("drain_next_out", b.out, 32'h4);
    check("drain_next_code", b.out_code, 5'd2);
    step();

    // Reset in the middle of a sweep.
    send(2'd2, 5'd31);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (b.out_valid && b.out_code == 5'd5) found = 1'b1;
    end
    check("rst_sweep_reach5", found, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", b.out_valid, 1'b0);
    check("arst_out", b.out, 32'd0);
    check("arst_busy", b.busy, 1'b0);
    check("arst_done", b.sweep_done, 1'b0);
    check("arst_ready", b.in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rerst_ready", b.in_ready, 1'b1);
    check("rerst_done", b.sweep_done, 1'b0);
    step();

    // Reserved mode.
    send(2'd3, 5'd9);
    @(negedge clk);
    check("err_pulse", b.err, 1'b1);
    check("err_no_valid", b.out_valid, 1'b0);
    step();
    @(negedge clk);
    check("err_clear", b.err, 1'b0);
    step();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = int'($urandom_range(0, 15));
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.in_valid  = ($urandom_range(0, 2) != 0);
      b.in_mode   = (r < 7) ? 2'd0 : (r < 13) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      b.in_code   = 5'($urandom);
      step();
    end
    b.in_valid  = 1'b0;
    b.out_ready = 1'b1;
    repeat (40) step();
    check("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
